// File: rtl/adbg_pkg.sv
// Shared definitions for the advanced debug interface receive path.
// FSM encoding, CRC length and the framing start-bit value.
package adbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_DATA       = 2'd2,
        ST_CRC        = 2'd3
    } state_e;

    localparam int   CRC_LEN   = 32;
    localparam int   CRC_CNT_W = $clog2(CRC_LEN);
    localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/adbg_word_deser.sv
// Serial-to-parallel word assembler, LSB first; done_o strobes combinationally
// with the last bit of a word, and word_o already includes that bit.
module adbg_word_deser #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              bit_vld_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] word_o,
    output logic              done_o
);

    localparam int              BC_W = $clog2(WORD_W) + 1;
    localparam logic [BC_W-1:0] LAST = BC_W'(WORD_W - 1);

    // Only WORD_W-1 bits are stored: the final bit goes straight to word_o.
    logic [WORD_W-2:0] sr_q;
    logic [BC_W-1:0]   cnt_q;

    assign word_o = {bit_i, sr_q};
    assign done_o = bit_vld_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (bit_vld_i) begin
            sr_q  <= word_o[WORD_W-1:1];
            cnt_q <= done_o ? '0 : cnt_q + BC_W'(1);
        end
    end

endmodule

// File: rtl/adbg_burst_rx.sv
// Burst-write receiver: deserialises SHIFT-DR data into words, feeds the external
// bit-serial CRC-32 unit and checks the host's trailing CRC against its output.
module adbg_burst_rx
    import adbg_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  burst_words_i,
    input  logic              tdi_i,
    input  logic              shift_en_i,
    input  logic              update_i,
    output logic              crc_data_o,
    output logic              crc_en_o,
    output logic              crc_shift_o,
    output logic              crc_clr_o,
    input  logic              crc_serial_i,
    output logic [WORD_W-1:0] wdata_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic              overflow_o,
    output logic              crc_ok_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              tdo_o
);

    localparam logic [CRC_CNT_W-1:0] CRC_LAST = CRC_CNT_W'(CRC_LEN - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CRC_CNT_W-1:0]   crc_bits_q;
    logic                   mismatch_q;
    logic                   mismatch_d;
    logic                   crc_ok_q;
    logic                   done_q;
    logic                   overflow_q;
    logic [WORD_W-1:0]      wdata_q;
    logic                   wvalid_q;

    logic                   bit_ok;
    logic                   data_bit_vld;
    logic                   deser_clr;
    logic [WORD_W-1:0]      deser_word;
    logic                   word_done;

    // update_i outranks shift_en_i: a bit arriving with it is never consumed.
    assign bit_ok       = shift_en_i && !update_i;
    assign data_bit_vld = (state_q == ST_DATA) && bit_ok;
    assign deser_clr    = (state_q != ST_DATA) || update_i;

    assign crc_en_o     = data_bit_vld;
    assign crc_data_o   = data_bit_vld & tdi_i;
    assign crc_shift_o  = (state_q == ST_CRC) && bit_ok;
    assign crc_clr_o    = !rst && (state_q == ST_IDLE) && start_i;
    assign mismatch_d   = mismatch_q | (tdi_i ^ crc_serial_i);

    assign wdata_o      = wdata_q;
    assign wvalid_o     = wvalid_q;
    assign overflow_o   = overflow_q;
    assign crc_ok_o     = crc_ok_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign tdo_o        = ((state_q == ST_IDLE) || (state_q == ST_WAIT_START)) && crc_ok_q;

    adbg_word_deser #(
        .WORD_W (WORD_W)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (deser_clr),
        .bit_vld_i (data_bit_vld),
        .bit_i     (tdi_i),
        .word_o    (deser_word),
        .done_o    (word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            crc_bits_q <= '0;
            mismatch_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A word completing into a full, unaccepted holding register is lost.
            if (word_done) begin
                if (!wvalid_q || wready_i) begin
                    wdata_q  <= deser_word;
                    wvalid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (wvalid_q && wready_i) begin
                wvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cnt_q      <= burst_words_i;
                        overflow_q <= 1'b0;
                        crc_ok_q   <= 1'b0;
                        mismatch_q <= 1'b0;
                        state_q    <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (update_i) begin
                        state_q <= ST_IDLE;
                    end else if (shift_en_i && (tdi_i == START_BIT)) begin
                        crc_bits_q <= '0;
                        state_q    <= (cnt_q == '0) ? ST_CRC : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (update_i) begin
                        state_q <= ST_IDLE;
                    end else if (word_done) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            crc_bits_q <= '0;
                            state_q    <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (update_i) begin
                        state_q <= ST_IDLE;
                    end else if (shift_en_i) begin
                        mismatch_q <= mismatch_d;
                        if (crc_bits_q == CRC_LAST) begin
                            crc_ok_q <= !mismatch_d;
                            done_q   <= 1'b1;
                            state_q  <= ST_IDLE;
                        end else begin
                            crc_bits_q <= crc_bits_q + CRC_CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adbg_burst_rx.sv
// Randomised bench for adbg_burst_rx with a behavioural CRC-32 unit on the CRC ports
// and a word-list/CRC reference model computed directly from the data being sent.
module tb_adbg_burst_rx;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [CNT_W-1:0]  burst_words_i;
    logic              tdi_i;
    logic              shift_en_i;
    logic              update_i;
    logic              crc_data_o;
    logic              crc_en_o;
    logic              crc_shift_o;
    logic              crc_clr_o;
    logic              crc_serial_i;
    logic [WORD_W-1:0] wdata_o;
    logic              wvalid_o;
    logic              wready_i;
    logic              overflow_o;
    logic              crc_ok_o;
    logic              done_o;
    logic              busy_o;
    logic              tdo_o;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                done_cnt = 0;
    bit                rand_rdy = 1'b1;
    logic [31:0]       tx_q[$];
    logic [31:0]       got_q[$];
    logic [31:0]       crc_reg;

    always #5 clk = ~clk;

    adbg_burst_rx #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .burst_words_i (burst_words_i),
        .tdi_i         (tdi_i),
        .shift_en_i    (shift_en_i),
        .update_i      (update_i),
        .crc_data_o    (crc_data_o),
        .crc_en_o      (crc_en_o),
        .crc_shift_o   (crc_shift_o),
        .crc_clr_o     (crc_clr_o),
        .crc_serial_i  (crc_serial_i),
        .wdata_o       (wdata_o),
        .wvalid_o      (wvalid_o),
        .wready_i      (wready_i),
        .overflow_o    (overflow_o),
        .crc_ok_o      (crc_ok_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .tdo_o         (tdo_o)
    );

    // Reflected CRC-32 unit as it sits next to the receiver in the debug module.
    always @(posedge clk) begin
        if (crc_clr_o)
            crc_reg <= 32'hFFFF_FFFF;
        else if (crc_en_o)
            crc_reg <= (crc_reg >> 1) ^ (((crc_reg[0] ^ crc_data_o) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
        else if (crc_shift_o)
            crc_reg <= crc_reg >> 1;
    end
    assign crc_serial_i = crc_reg[0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wvalid_o && wready_i) got_q.push_back(wdata_o);
        if (!rst && done_o) done_cnt++;
        if (crc_en_o && crc_shift_o) check("en_shift_excl", 1, 0);
    end

    function automatic logic [31:0] ref_crc(input logic [31:0] words[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (words[i]) begin
            for (int j = 0; j < 32; j++) begin
                fb = c[0] ^ words[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) wready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_bit(input logic b);
        if ($urandom_range(0, 4) == 0) begin
            shift_en_i = 1'b0;
            tdi_i      = 1'($urandom);
            tick();
        end
        shift_en_i = 1'b1;
        tdi_i      = b;
        tick();
        shift_en_i = 1'b0;
        tdi_i      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) send_bit(w[i]);
    endtask

    task automatic do_start(input int n);
        got_q.delete();
        start_i       = 1'b1;
        burst_words_i = CNT_W'(n);
        tick();
        start_i       = 1'b0;
    endtask

    task automatic check_beats();
        check("beat_cnt", 64'(got_q.size()), 64'(tx_q.size()));
        for (int i = 0; i < tx_q.size() && i < got_q.size(); i++)
            check("beat_data", got_q[i], tx_q[i]);
    endtask

    // Full burst from tx_q; flip corrupts the transmitted CRC.
    task automatic run_burst(input logic [31:0] flip, input int lead);
        logic exp_ok;
        exp_ok = (flip == 32'h0);
        do_start(tx_q.size());
        repeat (lead) send_bit(1'b0);
        send_bit(1'b1);
        foreach (tx_q[i]) send_word(tx_q[i]);
        send_word(ref_crc(tx_q) ^ flip);
        check("done", done_o, 1);
        check("crc_ok", crc_ok_o, exp_ok);
        check("tdo", tdo_o, exp_ok);
        tick();
        check("done_pulse", done_o, 0);
        check("busy_after", busy_o, 0);
        repeat (4) tick();
        check_beats();
    endtask

    initial begin
        logic [31:0] w;
        int          d0;
        rst = 1'b1; start_i = 1'b0; burst_words_i = '0; tdi_i = 1'b0;
        shift_en_i = 1'b0; update_i = 1'b0; wready_i = 1'b1;
        tick(); tick();
        check("rst_busy", busy_o, 0);
        check("rst_wvalid", wvalid_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ok", crc_ok_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_tdo", tdo_o, 0);
        check("rst_crcctl", {crc_clr_o, crc_en_o, crc_shift_o, crc_data_o}, 0);
        rst = 1'b0;
        tick();

        // Directed two-word burst, good and corrupted CRC.
        tx_q = '{32'hDEAD_BEEF, 32'h1234_5678};
        run_burst(32'h0, 0);
        run_burst(32'h0000_0080, 1);

        // Empty burst behind three leading zeros.
        tx_q.delete();
        run_burst(32'h0, 3);

        // Consumer stalled for three words.
        rand_rdy = 1'b0;
        wready_i = 1'b0;
        tx_q = '{$urandom, $urandom, $urandom};
        do_start(3);
        send_bit(1'b1);
        for (int i = 0; i < 31; i++) send_bit(tx_q[0][i]);
        check("lat_pre", wvalid_o, 0);
        send_bit(tx_q[0][31]);
        check("lat_post", wvalid_o, 1);
        check("lat_data", wdata_o, tx_q[0]);
        send_word(tx_q[1]);
        send_word(tx_q[2]);
        send_word(ref_crc(tx_q));
        check("ovf_done", done_o, 1);
        check("ovf_crc_ok", crc_ok_o, 1);
        check("ovf_wvalid", wvalid_o, 1);
        check("ovf_wdata", wdata_o, tx_q[0]);
        check("ovf_flag", overflow_o, 1);
        wready_i = 1'b1;
        tick(); tick();
        check("ovf_drain", wvalid_o, 0);
        check("ovf_beats", 64'(got_q.size()), 1);
        if (got_q.size() > 0) check("ovf_beat0", got_q[0], tx_q[0]);
        rand_rdy = 1'b1;
        do_start(0);
        check("ovf_clr", overflow_o, 0);
        check("ok_clr", crc_ok_o, 0);
        send_bit(1'b1);
        send_word(32'hFFFF_FFFF);
        check("ovf_next_ok", crc_ok_o, 1);
        tick();

        // Abort part-way through the second word of a four-word burst.
        tx_q = '{$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        do_start(4);
        send_bit(1'b1);
        send_word(tx_q[0]);
        for (int i = 0; i < 8; i++) send_bit(tx_q[1][i]);
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check("upd_busy", busy_o, 0);
        repeat (12) tick();
        check("upd_nodone", 64'(done_cnt), 64'(d0));
        check("upd_crc_ok", crc_ok_o, 0);
        check("upd_tdo", tdo_o, 0);
        check("upd_beats", 64'(got_q.size()), 1);
        if (got_q.size() > 0) check("upd_beat0", got_q[0], tx_q[0]);

        // Reset in the middle of the CRC phase.
        w = $urandom | 32'h1;
        tx_q = '{w};
        do_start(1);
        send_bit(1'b1);
        send_word(w);
        for (int i = 0; i < 10; i++) send_bit(ref_crc(tx_q) >> i);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_out", {wvalid_o, overflow_o, crc_ok_o, done_o, tdo_o}, 0);
        check("mid_rst_wdata", wdata_o, 0);
        rst = 1'b0;
        tick();
        tx_q = '{$urandom, $urandom};
        run_burst(32'h0, 2);

        // Random bursts.
        for (int k = 0; k < 5; k++) begin
            tx_q.delete();
            repeat ($urandom_range(0, 3)) tx_q.push_back($urandom);
            run_burst(($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
                      $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
